// File: rtl/midi_note_parser_pkg.sv
// Shared definitions for the MIDI note parser: status codes, note range,
// setpoint geometry, parser state type and the elaboration-time period math.
package midi_note_parser_pkg;

  localparam logic [3:0] ST_NOTE_OFF   = 4'h8;
  localparam logic [3:0] ST_NOTE_ON    = 4'h9;
  localparam logic [3:0] ST_PROG       = 4'hC;
  localparam logic [3:0] ST_CHAN_PRESS = 4'hD;
  localparam logic [7:0] SYS_FIRST     = 8'hF0;
  localparam logic [7:0] RT_FIRST      = 8'hF8;

  localparam int unsigned NOTE_MIN   = 24;
  localparam int unsigned NOTE_MAX   = 83;
  localparam int unsigned NOTE_COUNT = NOTE_MAX - NOTE_MIN + 1;
  localparam int unsigned SP_W       = 22;
  localparam int unsigned DRIVES     = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA1,
    S_DATA2,
    S_SKIP
  } parser_state_e;

  // Equal-tempered frequencies of notes 72..83 in nanohertz; lower octaves halve.
  function automatic logic [63:0] top_freq_nhz(input int unsigned k);
    case (k)
      0:       return 64'd523251130601;
      1:       return 64'd554365261954;
      2:       return 64'd587329535835;
      3:       return 64'd622253967444;
      4:       return 64'd659255113826;
      5:       return 64'd698456462866;
      6:       return 64'd739988845423;
      7:       return 64'd783990871963;
      8:       return 64'd830609395160;
      9:       return 64'd880000000000;
      10:      return 64'd932327523036;
      default: return 64'd987766602512;
    endcase
  endfunction

  // round(clk_rate / f(note)), evaluated only on constants at elaboration.
  function automatic logic [SP_W-1:0] note_period(input int unsigned clk_rate,
                                                  input int unsigned note);
    logic [95:0] num;
    logic [95:0] den;
    num = (96'(clk_rate) * 96'd1000000000) << (6 - note / 12);
    den = 96'(top_freq_nhz(note % 12));
    return SP_W'((2 * num + den) / (2 * den));
  endfunction

endpackage

// File: rtl/midi_note_parser_note_period_rom.sv
// Note-to-step-period table for notes 24..83 with a registered, enabled read port.
module note_period_rom
  import midi_note_parser_pkg::*;
#(
  parameter int unsigned CLK_RATE = 50000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [5:0]      addr,
  output logic [SP_W-1:0] period
);

  logic [SP_W-1:0] table_w [NOTE_COUNT];

  for (genvar i = 0; i < NOTE_COUNT; i++) begin : g_entry
    localparam logic [SP_W-1:0] P = note_period(CLK_RATE, NOTE_MIN + i);
    assign table_w[i] = P;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period <= '0;
    end else if (en) begin
      period <= (addr < 6'(NOTE_COUNT)) ? table_w[addr] : '0;
    end
  end

endmodule

// File: rtl/midi_note_parser.sv
// MIDI byte-stream parser driving eight step-motor "drives" from Note On/Off
// messages: running-status FSM, per-drive note tracking, period lookup.
module midi_note_parser
  import midi_note_parser_pkg::*;
#(
  parameter int unsigned CLK_RATE  = 50000000,
  parameter int unsigned BASE_CHAN = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_new,
  output logic        sp_valid,
  output logic [2:0]  sp_chan,
  output logic        sp_en,
  output logic [21:0] sp_value,
  output logic [7:0]  active
);

  parser_state_e state_q, state_d;
  logic [3:0] cmd_q, cmd_d;
  logic [3:0] chan_q, chan_d;
  logic [6:0] data1_q, data1_d;

  logic       msg_done;
  logic [6:0] msg_note;
  logic [6:0] msg_vel;

  logic [6:0]        notes_q [DRIVES];
  logic [DRIVES-1:0] active_d;
  logic              note_wr;
  logic              upd_valid;
  logic              upd_en;

  logic [3:0] drv_rel;
  logic [2:0] drv;
  logic       drv_ok;
  logic       note_ok;
  logic       is_on;
  logic       is_off;

  logic            p_valid;
  logic [2:0]      p_chan;
  logic            p_en;
  logic [5:0]      p_idx;
  logic [SP_W-1:0] rom_period;

  // Realtime bytes fall through untouched so a partial message survives them.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    chan_d   = chan_q;
    data1_d  = data1_q;
    msg_done = 1'b0;
    msg_note = data1_q;
    msg_vel  = rx_data[6:0];
    if (rx_new) begin
      if (rx_data >= RT_FIRST) begin
        state_d = state_q;
      end else if (rx_data >= SYS_FIRST) begin
        state_d = S_SKIP;
        cmd_d   = '0;
        chan_d  = '0;
      end else if (rx_data[7]) begin
        state_d = S_DATA1;
        cmd_d   = rx_data[7:4];
        chan_d  = rx_data[3:0];
      end else begin
        case (state_q)
          S_DATA1: begin
            if (cmd_q == ST_PROG || cmd_q == ST_CHAN_PRESS) begin
              msg_done = 1'b1;
              msg_note = rx_data[6:0];
              msg_vel  = '0;
            end else begin
              data1_d = rx_data[6:0];
              state_d = S_DATA2;
            end
          end
          S_DATA2: begin
            msg_done = 1'b1;
            state_d  = S_DATA1;
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  assign drv_rel = chan_q - 4'(BASE_CHAN);
  assign drv     = drv_rel[2:0];
  assign drv_ok  = (chan_q >= 4'(BASE_CHAN)) && !drv_rel[3];
  assign note_ok = (msg_note >= 7'(NOTE_MIN)) && (msg_note <= 7'(NOTE_MAX));
  assign is_on   = (cmd_q == ST_NOTE_ON) && (msg_vel != '0);
  assign is_off  = (cmd_q == ST_NOTE_OFF) || ((cmd_q == ST_NOTE_ON) && (msg_vel == '0));

  always_comb begin
    upd_valid = 1'b0;
    upd_en    = 1'b0;
    note_wr   = 1'b0;
    active_d  = active;
    if (msg_done && drv_ok && note_ok) begin
      if (is_on) begin
        upd_valid     = 1'b1;
        upd_en        = 1'b1;
        note_wr       = 1'b1;
        active_d[drv] = 1'b1;
      end else if (is_off && active[drv] && (notes_q[drv] == msg_note)) begin
        upd_valid     = 1'b1;
        active_d[drv] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      chan_q   <= '0;
      data1_q  <= '0;
      active   <= '0;
      for (int unsigned i = 0; i < DRIVES; i++) notes_q[i] <= '0;
      p_valid  <= 1'b0;
      p_chan   <= '0;
      p_en     <= 1'b0;
      p_idx    <= '0;
      sp_valid <= 1'b0;
      sp_chan  <= '0;
      sp_en    <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      chan_q  <= chan_d;
      data1_q <= data1_d;
      active  <= active_d;
      if (note_wr) notes_q[drv] <= msg_note;
      p_valid <= upd_valid;
      if (upd_valid) begin
        p_chan <= drv;
        p_en   <= upd_en;
        p_idx  <= 6'(msg_note - 7'(NOTE_MIN));
      end
      sp_valid <= p_valid;
      if (p_valid) begin
        sp_chan <= p_chan;
        sp_en   <= p_en;
      end
    end
  end

  note_period_rom #(
    .CLK_RATE(CLK_RATE)
  ) u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (p_valid && p_en),
    .addr  (p_idx),
    .period(rom_period)
  );

  // The ROM only loads on note-on, so a silenced drive reports zero here.
  assign sp_value = sp_en ? rom_period : '0;

endmodule
